// File: rtl/ex_stage_unit_if.sv
// Execute-stage bus: ID/EX bundle in, forwarding sources in, EX/MEM bundle and stall out.
// slave is the execute stage; master is whatever drives the pipeline registers around it.
interface ex_stage_unit_if;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i;
    logic        RegWrite_i;
    logic        MemWrite_i;
    logic        MemRead_i;
    logic        Mem2Reg_i;
    logic [31:0] RSdata_i;
    logic [31:0] RTdata_i;
    logic [31:0] imm_i;
    logic [9:0]  funct_i;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic [4:0]  RDaddr_i;

    logic        exmem_RegWrite_i;
    logic [4:0]  exmem_RDaddr_i;
    logic [31:0] exmem_data_i;
    logic        memwb_RegWrite_i;
    logic [4:0]  memwb_RDaddr_i;
    logic [31:0] memwb_data_i;

    logic [31:0] ALUres_o;
    logic [31:0] MemWdata_o;
    logic [4:0]  RDaddr_o;
    logic        RegWrite_o;
    logic        MemWrite_o;
    logic        MemRead_o;
    logic        Mem2Reg_o;
    logic        stall_o;

    modport slave (
        input  ALUOp_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i,
        input  RSdata_i, RTdata_i, imm_i, funct_i, RSaddr_i, RTaddr_i, RDaddr_i,
        input  exmem_RegWrite_i, exmem_RDaddr_i, exmem_data_i,
        input  memwb_RegWrite_i, memwb_RDaddr_i, memwb_data_i,
        output ALUres_o, MemWdata_o, RDaddr_o,
        output RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, stall_o
    );

    modport master (
        output ALUOp_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i,
        output RSdata_i, RTdata_i, imm_i, funct_i, RSaddr_i, RTaddr_i, RDaddr_i,
        output exmem_RegWrite_i, exmem_RDaddr_i, exmem_data_i,
        output memwb_RegWrite_i, memwb_RDaddr_i, memwb_data_i,
        input  ALUres_o, MemWdata_o, RDaddr_o,
        input  RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, stall_o
    );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Define EX_MUL_EN to build the iterative shift-add multiplier and its stall FSM.
//
// state  | meaning
// S_IDLE | single-cycle ops pass through; a MUL latches operands and stalls
// S_BUSY | one shift-add step per cycle; the final step writes EX/MEM
module ex_stage_unit #(
    parameter int MUL_STEPS = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ex_stage_unit_if.slave bus
);
    localparam int W = 32;

    localparam logic [9:0] F_ADD = 10'b0000000_000;
    localparam logic [9:0] F_SUB = 10'b0100000_000;
    localparam logic [9:0] F_AND = 10'b0000000_111;
    localparam logic [9:0] F_XOR = 10'b0000000_100;
    localparam logic [9:0] F_SLL = 10'b0000000_001;
    localparam logic [9:0] F_MUL = 10'b0000001_000;

    if (MUL_STEPS != W) begin : g_steps_check
        $error("ex_stage_unit: MUL_STEPS must equal the data width");
    end

    // EX/MEM wins over MEM/WB because it holds the younger write; x0 never forwards.
    function automatic logic [W-1:0] fwd_sel(
        input logic [4:0]   src,
        input logic [W-1:0] rf_data,
        input logic         ex_we,
        input logic [4:0]   ex_rd,
        input logic [W-1:0] ex_data,
        input logic         wb_we,
        input logic [4:0]   wb_rd,
        input logic [W-1:0] wb_data
    );
        logic [W-1:0] res;
        res = rf_data;
        if (ex_we && (ex_rd != 5'd0) && (ex_rd == src)) begin
            res = ex_data;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            res = wb_data;
        end
        return res;
    endfunction

    logic [W-1:0] opa;
    logic [W-1:0] fwd_rt;
    logic [W-1:0] opb;
    logic [W-1:0] alu_res;
    logic [W-1:0] ex_result;
    logic         ex_bubble;
    logic         stall;

    assign opa = fwd_sel(bus.RSaddr_i, bus.RSdata_i,
                         bus.exmem_RegWrite_i, bus.exmem_RDaddr_i, bus.exmem_data_i,
                         bus.memwb_RegWrite_i, bus.memwb_RDaddr_i, bus.memwb_data_i);
    assign fwd_rt = fwd_sel(bus.RTaddr_i, bus.RTdata_i,
                            bus.exmem_RegWrite_i, bus.exmem_RDaddr_i, bus.exmem_data_i,
                            bus.memwb_RegWrite_i, bus.memwb_RDaddr_i, bus.memwb_data_i);
    assign opb = bus.ALUSrc_i ? bus.imm_i : fwd_rt;

    always_comb begin
        alu_res = '0;
        case (bus.ALUOp_i)
            2'b00: alu_res = opa + opb;
            2'b01: alu_res = opa - opb;
            2'b10: begin
                case (bus.funct_i)
                    F_ADD:   alu_res = opa + opb;
                    F_SUB:   alu_res = opa - opb;
                    F_AND:   alu_res = opa & opb;
                    F_XOR:   alu_res = opa ^ opb;
                    F_SLL:   alu_res = opa << opb[4:0];
`ifndef EX_MUL_EN
                    F_MUL:   alu_res = opa + opb;
`endif
                    default: alu_res = '0;
                endcase
            end
            default: begin
                // SRAI takes its shift amount from the immediate even if ALUSrc is low
                if (bus.funct_i[2:0] == 3'b101) begin
                    alu_res = $unsigned($signed(opa) >>> bus.imm_i[4:0]);
                end else begin
                    alu_res = opa + opb;
                end
            end
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CW = $clog2(MUL_STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

    typedef enum logic [0:0] {
        S_IDLE,
        S_BUSY
    } mul_state_t;

    mul_state_t    state_q;
    mul_state_t    state_d;
    logic [CW-1:0] step_q;
    logic [CW-1:0] step_d;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  mplier_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_next;
    logic          is_mul_op;
    logic          load_mul;
    logic          do_step;
    logic          mul_done;

    assign is_mul_op = (bus.ALUOp_i == 2'b10) && (bus.funct_i == F_MUL);
    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        stall    = 1'b0;
        load_mul = 1'b0;
        do_step  = 1'b0;
        mul_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mul_op) begin
                    stall    = 1'b1;
                    load_mul = 1'b1;
                    step_d   = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                do_step = 1'b1;
                if (step_q == LAST_STEP) begin
                    mul_done = 1'b1;
                    step_d   = '0;
                    state_d  = S_IDLE;
                end else begin
                    stall  = 1'b1;
                    step_d = step_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Operands are captured once so forwarding ports may change while busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load_mul) begin
            mcand_q  <= opa;
            mplier_q <= opb;
            acc_q    <= '0;
        end else if (do_step) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_next;
        end
    end

    // Every stalled cycle (operand capture and non-final steps) emits a bubble.
    assign ex_bubble = stall;
    assign ex_result = mul_done ? acc_next : alu_res;
`else
    assign stall     = 1'b0;
    assign ex_bubble = 1'b0;
    assign ex_result = alu_res;
`endif

    logic [W-1:0] alu_q;
    logic [W-1:0] wdata_q;
    logic [4:0]   rd_q;
    logic         regwrite_q;
    logic         memwrite_q;
    logic         memread_q;
    logic         mem2reg_q;

    // Bubbles clear only the control bits; data is held to avoid needless toggling.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_q      <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            mem2reg_q  <= 1'b0;
        end else if (ex_bubble) begin
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            mem2reg_q  <= 1'b0;
        end else begin
            alu_q      <= ex_result;
            wdata_q    <= fwd_rt;
            rd_q       <= bus.RDaddr_i;
            regwrite_q <= bus.RegWrite_i;
            memwrite_q <= bus.MemWrite_i;
            memread_q  <= bus.MemRead_i;
            mem2reg_q  <= bus.Mem2Reg_i;
        end
    end

    assign bus.ALUres_o   = alu_q;
    assign bus.MemWdata_o = wdata_q;
    assign bus.RDaddr_o   = rd_q;
    assign bus.RegWrite_o = regwrite_q;
    assign bus.MemWrite_o = memwrite_q;
    assign bus.MemRead_o  = memread_q;
    assign bus.Mem2Reg_o  = mem2reg_q;
    assign bus.stall_o    = stall;
endmodule

// File: doc/ex_stage_unit.md
Name: ex_stage_unit

Overview:
- Execute stage of the pipelined CPU. It consumes the decoded bundle driven by the ID/EX pipeline register and computes the ALU result, with operand forwarding from EX/MEM and MEM/WB.
- It registers the result bundle toward the MEM stage, acting as the EX/MEM register.
- It includes an iterative 32-step multiplier. While the multiplier runs, the unit asserts stall_o so the PC, IF/ID and ID/EX hold their contents.

Parameters:
- MUL_STEPS, 32, number of shift-add iterations; must equal the data width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ALUOp_i  in  2  ALU op class from ID/EX.
- ALUSrc_i  in  1  1 selects imm_i as operand B.
- RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i  in  1 each  control bits from ID/EX.
- RSdata_i, RTdata_i  in  32 each  register file read data.
- imm_i  in  32  sign-extended immediate.
- funct_i  in  10  {funct7[6:0], funct3[2:0]}.
- RSaddr_i, RTaddr_i, RDaddr_i  in  5 each  register addresses.
- exmem_RegWrite_i  in  1  forwarding source 1: write enable.
- exmem_RDaddr_i  in  5  forwarding source 1: destination address.
- exmem_data_i  in  32  forwarding source 1: data.
- memwb_RegWrite_i  in  1  forwarding source 2: write enable.
- memwb_RDaddr_i  in  5  forwarding source 2: destination address.
- memwb_data_i  in  32  forwarding source 2: write-back data.
- ALUres_o  out  32  registered result / memory address.
- MemWdata_o  out  32  registered store data (forwarded RT).
- RDaddr_o  out  5  registered destination address.
- RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o  out  1 each  registered control bits.
- stall_o  out  1  combinational freeze request to PC, IF/ID and ID/EX.

Behaviour:
- Reset:
  - All registered outputs reset to 0.
  - FSM resets to IDLE and the step counter to 0.
  - Reset mid-multiply abandons the operation; no result is written.
- Forwarding, per operand (RS→A, RT→B):
  - Take exmem_data_i if exmem_RegWrite_i=1, exmem_RDaddr_i≠0 and exmem_RDaddr_i equals the source address.
  - Otherwise take memwb_data_i under the same three conditions using the memwb ports.
  - Otherwise take the register file data.
  - Address 0 never forwards.
- Operand B and store data: B = ALUSrc_i ? imm_i : forwarded RT. MemWdata_o always takes forwarded RT.
- ALUOp 00: A+B (load/store address).
- ALUOp 01: A-B.
- ALUOp 10 (R-type), decoded on funct_i:
  - 0000000_000 ADD
  - 0100000_000 SUB
  - 0000000_111 AND
  - 0000000_100 XOR
  - 0000000_001 SLL by B[4:0]
  - 0000001_000 MUL
  - any other code gives result 0.
- ALUOp 11 (I-type), decoded on funct3:
  - 000 ADDI
  - 101 SRAI, arithmetic shift of A by imm_i[4:0]
  - any other code gives ADDI.
- Arithmetic wraps modulo 2^32. MUL keeps the low 32 bits of the unsigned product, which equals the signed low word.
- Non-MUL latency: 1 cycle. The result and control bits register at the next rising edge.
- FSM states:
  - IDLE: if the incoming op is MUL (ALUOp=10, funct=0000001_000):
    - stall_o=1.
    - Forwarded A and B latch into the multiplicand/multiplier registers; the accumulator clears.
    - EX/MEM loads a bubble: all control outputs 0, data outputs don't-care but held.
    - Go to BUSY with counter 0.
  - BUSY: each cycle performs one shift-add step and increments the counter.
    - stall_o=1 while the counter is not MUL_STEPS-1.
    - When the counter equals MUL_STEPS-1, stall_o=0. The final step's product, RDaddr_i and the control bits register into EX/MEM at that edge, and the FSM returns to IDLE.
- MUL occupancy:
  - stall_o is high for 32 cycles; the MUL occupies EX for 33 cycles.
  - ID/EX advances at the final edge, so the same MUL is not re-detected.
- Bubbles while BUSY: EX/MEM outputs bubbles, and older instructions drain through MEM/WB. Latched operands make the result independent of the forwarding ports after the IDLE cycle.
- A MUL immediately following a MUL is detected in IDLE at the cycle after completion, with no gap.
- Load-use hazards are not detected here; the hazard unit owns them.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: iterative multiplier and FSM present, as specified above.
- Undefined:
  - No FSM and no multiplier registers; stall_o tied to 0.
  - funct 0000001_000 under ALUOp 10 decodes as ADD.
  - All ops have 1-cycle latency.

Test Plan:
- Reset: assert rst_i mid-cycle → all outputs 0 immediately, asynchronous to clk_i; stall_o=0 while ID/EX presents a non-MUL op.
- R-type SUB, RS=5, RT=3, RSdata=10, RTdata=25, RD=7, no forwarding → next edge ALUres_o=0xFFFFFFF1, RDaddr_o=7, RegWrite_o=1.
- Forwarding priority, RSaddr=4:
  - exmem matches with 0x11 and memwb matches with 0x22 → A=0x11.
  - exmem_RDaddr=0 → no forward from it.
  - RDaddr=0 on both paths → RSdata used.
- Store, ALUOp=00, ALUSrc=1, imm=8, forwarded RS=0x100, RT forwarded from memwb=0xAB → ALUres_o=0x108, MemWdata_o=0xAB, MemWrite_o=1.
- MUL 0xFFFFFFFF×3 with EX_MUL_EN:
  - stall_o high for exactly 32 cycles.
  - EX/MEM control outputs 0 during the operation.
  - On the 33rd cycle edge, ALUres_o=0xFFFFFFFD and RegWrite_o=1.
  - rst_i pulsed at step 10 of a repeat run → outputs 0, no result written.
- SRAI A=0x80000010, imm=4 → 0xF8000001. Without EX_MUL_EN, MUL funct with operands 6 and 7 → 13, stall_o=0.
